stepper_pulse_gen: RTL and testbench
====================================

STEPPER_PULSE_GEN -- requirements
Module: stepper_pulse_gen

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 200: step_out high time in clocks (2 us at 100 MHz).
REQ-002 SHALL have parameter DIR_SETUP_CYCLES, default 500: dir_out-to-step_out rising-edge setup in clocks.
REQ-003 SHALL have parameter MIN_PERIOD, default 1000: minimum step period in clocks; must be at least 2*PULSE_CYCLES.
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  in  1  motion permitted.
REQ-007 SHALL have port speed  in  32  step period in clocks; 0 = stop.
REQ-008 SHALL have port direction  in  1  requested direction; 1 = left/up (negative), 0 = right/down (positive).
REQ-009 SHALL have port pos_clear  in  1  synchronous position clear.
REQ-010 SHALL have port step_out  out  1  registered step pulse to driver pin.
REQ-011 SHALL have port dir_out  out  1  registered direction to driver pin.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port position  out  32  signed step count.

Function
REQ-014 SHALL implement FSM states IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW with one 32-bit phase counter.
REQ-015 SHALL sample speed and direction only in IDLE and in the last cycle of PULSE_LOW, the period boundary; mid-period changes have no effect.
REQ-016 SHALL clamp the effective period to MIN_PERIOD when the sampled speed is nonzero and below MIN_PERIOD.
REQ-017 SHALL, from IDLE with enable=1, speed!=0 and direction==dir_out, enter PULSE_HIGH so step_out rises on the next clock edge.
REQ-018 SHALL, when the sampled direction differs from dir_out, update dir_out on the same edge, enter DIR_SETUP, and hold step_out low for DIR_SETUP_CYCLES clocks before PULSE_HIGH.
REQ-019 SHALL hold step_out high for exactly PULSE_CYCLES clocks in PULSE_HIGH, then hold it low in PULSE_LOW for effective period minus PULSE_CYCLES clocks.
REQ-020 SHALL never change dir_out while step_out is high or within DIR_SETUP_CYCLES before a step_out rising edge.
REQ-021 SHALL, at a period boundary, go to IDLE when enable=0 or speed=0; otherwise start the next period per REQ-017/REQ-018 with no idle gap.
REQ-022 SHALL, when enable falls or speed becomes 0 during PULSE_HIGH or PULSE_LOW, complete the high phase, hold low for at least PULSE_CYCLES clocks, then enter IDLE; no truncated pulse is emitted.
REQ-023 SHALL, when enable falls during DIR_SETUP, return to IDLE without a pulse; dir_out keeps its new value.
REQ-024 SHALL add 1 to position (dir_out=0) or subtract 1 (dir_out=1) on the edge where step_out rises, with two's-complement wrap (0x7FFFFFFF+1 -> 0x80000000).
REQ-025 SHALL give pos_clear priority over a simultaneous step update, so position = 0 on that edge.

Reset
REQ-026 SHALL, on reset low, asynchronously force state IDLE, step_out=0, dir_out=0, busy=0, position=0, phase counter=0.
REQ-027 SHALL, on reset asserted mid-pulse, drop step_out immediately and count no step for that pulse; release is synchronised by the next rising clock edge.

Configuration
REQ-028 SHALL, with macro STEPPER_POSITION_EN defined, implement the position counter per REQ-024/REQ-025.
REQ-029 SHALL, without STEPPER_POSITION_EN, tie position to 0, ignore pos_clear, and synthesise no position register; all other behaviour is unchanged.

Verification (bench params PULSE_CYCLES=4, DIR_SETUP_CYCLES=6, MIN_PERIOD=10)
REQ-030 SHALL cover: enable=1, speed=20, direction=0 from IDLE -> step_out rises 1 clk later, pattern 4 high/16 low, position +1 per pulse, busy=1.
REQ-031 SHALL cover: speed=3 -> effective period 10 (4 high/6 low).
REQ-032 SHALL cover: direction 0->1 while running at speed=20 -> dir_out toggles at the period boundary, 6 low clocks, next pulse decrements position.
REQ-033 SHALL cover: enable=0 on the 2nd high cycle -> 4-cycle pulse completes, 4 low clocks, then IDLE with busy=0.
REQ-034 SHALL cover: position preloaded to 0x7FFFFFFF with one step dir 0 -> 0x80000000; pos_clear on the same edge as a step -> 0.
REQ-035 SHALL cover: reset low mid-PULSE_HIGH -> step_out=0 immediately, position unchanged, state IDLE; repeat without STEPPER_POSITION_EN -> position constant 0.

Source files
------------

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for a stepper driver: fixed-width step pulses at a clamped period,
// with direction setup time and a signed position count (enabled by defining STEPPER_POSITION_EN).
module stepper_pulse_gen #(
  parameter int unsigned PULSE_CYCLES     = 200,
  parameter int unsigned DIR_SETUP_CYCLES = 500,
  parameter int unsigned MIN_PERIOD       = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] speed,
  input  logic        direction,
  input  logic        pos_clear,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic [31:0] position
);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;

  localparam logic [31:0] PULSE_LEN  = 32'(PULSE_CYCLES);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP_CYCLES - 1);
  localparam logic [31:0] MIN_P      = 32'(MIN_PERIOD);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] eff_period, low_last;
  logic        step_d, dir_d;
  logic        stop_q, stop_d;
  logic        step_rise, boundary;
  logic        go;

  assign eff_period = (speed < MIN_P) ? MIN_P : speed;
  assign low_last   = period_q - PULSE_LEN - 32'd1;
  assign go         = enable && (speed != '0);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    period_d  = period_q;
    step_d    = step_out;
    dir_d     = dir_out;
    stop_d    = stop_q;
    step_rise = 1'b0;
    boundary  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        stop_d   = 1'b0;
        boundary = 1'b1;
      end
      DIR_SETUP: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= SETUP_LAST) begin
          state_d   = PULSE_HIGH;
          step_d    = 1'b1;
          step_rise = 1'b1;
          cnt_d     = '0;
        end
      end
      PULSE_HIGH: begin
        stop_d = stop_q || !go;
        if (cnt_q >= PULSE_LAST) begin
          state_d = PULSE_LOW;
          step_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      PULSE_LOW: begin
        // A pending stop shortens the low phase to one pulse width; it never lengthens it.
        stop_d = stop_q || !go;
        if (stop_d && (cnt_q >= PULSE_LAST)) begin
          state_d = IDLE;
          cnt_d   = '0;
          stop_d  = 1'b0;
        end else if (cnt_q >= low_last) begin
          boundary = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Period boundary: the only place speed and direction are sampled.
    if (boundary) begin
      stop_d = 1'b0;
      cnt_d  = '0;
      if (!go) begin
        state_d = IDLE;
      end else begin
        period_d = eff_period;
        if (direction != dir_out) begin
          dir_d   = direction;
          state_d = DIR_SETUP;
        end else begin
          state_d   = PULSE_HIGH;
          step_d    = 1'b1;
          step_rise = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= MIN_P;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_out <= step_d;
      dir_out  <= dir_d;
      stop_q   <= stop_d;
    end
  end

`ifdef STEPPER_POSITION_EN
  logic [31:0] position_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      position_q <= '0;
    end else if (pos_clear) begin
      position_q <= '0;
    end else if (step_rise) begin
      position_q <= dir_out ? (position_q - 32'd1) : (position_q + 32'd1);
    end
  end

  assign position = position_q;
`else
  logic unused_pos;
  assign unused_pos = pos_clear ^ step_rise;
  assign position   = '0;
`endif

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen (PULSE_CYCLES=4, DIR_SETUP_CYCLES=6, MIN_PERIOD=10);
// position expectations follow STEPPER_POSITION_EN.
module tb_stepper_pulse_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] speed;
  logic        direction;
  logic        pos_clear;
  logic        step_out;
  logic        dir_out;
  logic        busy;
  logic [31:0] position;

  int compared   = 0;
  int mismatched = 0;

  stepper_pulse_gen #(
    .PULSE_CYCLES     (4),
    .DIR_SETUP_CYCLES (6),
    .MIN_PERIOD       (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .speed     (speed),
    .direction (direction),
    .pos_clear (pos_clear),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .position  (position)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ep(input logic [31:0] v);
`ifdef STEPPER_POSITION_EN
    return v;
`else
    return 32'(v & 32'd0);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks hi high samples then lo low samples, starting at the current sample.
  task automatic run_check(input string tag, input int hi, input int lo, input logic exp_dir);
    for (int i = 0; i < hi + lo; i++) begin
      chk($sformatf("%s_step%0d", tag, i), 32'(step_out), 32'(i < hi));
      chk($sformatf("%s_dir%0d", tag, i), 32'(dir_out), 32'(exp_dir));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      tick();
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    speed     = 32'd0;
    direction = 1'b0;
    pos_clear = 1'b0;
    #22;
    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_dir",  32'(dir_out),  32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_pos",  position,      32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Start from IDLE at speed 20, direction 0
    enable = 1'b1; speed = 32'd20; direction = 1'b0;
    tick();
    chk("start_step", 32'(step_out), 32'd1);
    chk("start_busy", 32'(busy),     32'd1);
    chk("start_pos",  position,      ep(32'd1));
    run_check("p20a", 4, 16, 1'b0);
    chk("p2_step", 32'(step_out), 32'd1);
    chk("p2_pos",  position,      ep(32'd2));

    // Mid-period speed change only takes effect at the next boundary; speed 3 clamps to 10
    speed = 32'd3;
    run_check("p20b", 4, 16, 1'b0);
    chk("p3_step", 32'(step_out), 32'd1);
    chk("p3_pos",  position,      ep(32'd3));
    run_check("clamp", 4, 6, 1'b0);
    chk("p4_step", 32'(step_out), 32'd1);
    chk("p4_pos",  position,      ep(32'd4));

    // Direction reversal: dir_out changes at the boundary, 6 setup clocks, then decrement
    speed = 32'd20; direction = 1'b1;
    run_check("pre_rev", 4, 6, 1'b0);
    chk("rev_dir",  32'(dir_out),  32'd1);
    chk("rev_step", 32'(step_out), 32'd0);
    run_check("setup", 0, 6, 1'b1);
    chk("rev_rise", 32'(step_out), 32'd1);
    chk("rev_pos",  position,      ep(32'd3));
    run_check("p20r", 4, 16, 1'b1);
    chk("rev2_step", 32'(step_out), 32'd1);
    chk("rev2_pos",  position,      ep(32'd2));

    // Enable drops on the 2nd high cycle: full pulse, 4 low clocks, then IDLE
    tick();
    enable = 1'b0;
    run_check("stop", 3, 4, 1'b1);
    chk("stop_busy", 32'(busy),     32'd0);
    chk("stop_step", 32'(step_out), 32'd0);
    chk("stop_pos",  position,      ep(32'd2));
    tick();
    chk("stop_stay", 32'(busy), 32'd0);

    // Enable drops during DIR_SETUP: back to IDLE, no pulse, dir_out keeps new value
    enable = 1'b1; direction = 1'b0;
    tick();
    chk("ds_dir",  32'(dir_out),  32'd0);
    chk("ds_busy", 32'(busy),     32'd1);
    chk("ds_step", 32'(step_out), 32'd0);
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("dsab_busy", 32'(busy),     32'd0);
    chk("dsab_dir",  32'(dir_out),  32'd0);
    chk("dsab_step", 32'(step_out), 32'd0);
    tick();
    chk("dsab_nopulse", 32'(step_out), 32'd0);
    chk("dsab_pos",     position,      ep(32'd2));

    // Wrap at +max, then pos_clear on the same edge as a step
`ifdef STEPPER_POSITION_EN
    dut.position_q = 32'h7FFF_FFFF;
    #1;
    chk("preload", position, 32'h7FFF_FFFF);
`endif
    enable = 1'b1; speed = 32'd20; direction = 1'b0;
    tick();
    chk("wrap_step", 32'(step_out), 32'd1);
    chk("wrap_pos",  position,      ep(32'h8000_0000));
    run_check("wrap", 4, 15, 1'b0);
    pos_clear = 1'b1;
    tick();
    pos_clear = 1'b0;
    chk("clr_step", 32'(step_out), 32'd1);
    chk("clr_pos",  position,      32'd0);

    // Reset asserted mid-PULSE_HIGH drops everything immediately
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_step", 32'(step_out), 32'd0);
    chk("arst_busy", 32'(busy),     32'd0);
    chk("arst_dir",  32'(dir_out),  32'd0);
    chk("arst_pos",  position,      32'd0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
    tick();
    chk("post_busy", 32'(busy),     32'd0);
    chk("post_step", 32'(step_out), 32'd0);
    chk("post_pos",  position,      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
